// File: rtl/alu_retire_pkg.sv
// Shared types and helpers for the ALU retire stage: tag kinds, jump conditions
// and the control portion of a queued instruction tag.
package alu_retire_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 8;

    typedef enum logic [1:0] {
        KIND_WB_A = 2'd0,
        KIND_JMP  = 2'd1,
        KIND_DROP = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        COND_EQ  = 2'd0,
        COND_GT  = 2'd1,
        COND_GE  = 2'd2,
        COND_SET = 2'd3
    } cond_e;

    // Control fields of a tag; the PC is appended by the top since its width is a parameter.
    typedef struct packed {
        kind_e              kind;
        cond_e              cond;
        logic [OFF_W-1:0]   jt;
        logic [OFF_W-1:0]   jf;
    } tag_ctl_t;

    function automatic logic cond_taken(input cond_e cond, input logic eq, input logic gt,
                                        input logic ge, input logic set);
        logic taken;
        case (cond)
            COND_EQ:  taken = eq;
            COND_GT:  taken = gt;
            COND_GE:  taken = ge;
            default:  taken = set;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/retire_tag_fifo.sv
// In-order tag FIFO with wrap-bit pointers; head is read combinationally from storage.
module retire_tag_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign full      = (w_count == (AW+1)'(DEPTH));
    assign empty     = (w_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_retire.sv
// Retire stage: pairs each ALU result with its issue-time tag and turns it into
// an A writeback pulse, a PC-load pulse, or nothing.
module alu_retire
    import alu_retire_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 10,
    parameter int unsigned TAG_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_vld,
    output logic                issue_rdy,
    input  logic [1:0]          issue_kind,
    input  logic [1:0]          issue_cond,
    input  logic [7:0]          issue_jt,
    input  logic [7:0]          issue_jf,
    input  logic [PC_WIDTH-1:0] issue_pc,
    input  logic [31:0]         ALU_out,
    input  logic                eq,
    input  logic                gt,
    input  logic                ge,
    input  logic                set,
    input  logic                ALU_vld,
    output logic                ALU_ack,
    output logic                A_wr_en,
    output logic [31:0]         A_wr_data,
    output logic                pc_ld_en,
    output logic [PC_WIDTH-1:0] pc_ld_val,
    output logic                idle,
    output logic                orphan_err
);

    localparam int unsigned CTL_W = $bits(tag_ctl_t);
    localparam int unsigned TAG_W = CTL_W + PC_WIDTH;

    tag_ctl_t              w_push_ctl;
    logic [TAG_W-1:0]      w_push_tag;
    logic [TAG_W-1:0]      w_head_tag;
    tag_ctl_t              w_head_ctl;
    logic [PC_WIDTH-1:0]   w_head_pc;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_taken;
    logic [OFF_W-1:0]      w_off;
    logic [PC_WIDTH-1:0]   w_target;
    logic                  w_is_wb;
    logic                  w_is_jmp;

    always_comb begin
        w_push_ctl      = '0;
        w_push_ctl.kind = kind_e'(issue_kind);
        w_push_ctl.cond = cond_e'(issue_cond);
        w_push_ctl.jt   = issue_jt;
        w_push_ctl.jf   = issue_jf;
    end

    assign w_push_tag = {w_push_ctl, issue_pc};

    retire_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_vld),
        .push_data (w_push_tag),
        .pop       (ALU_ack),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head_tag)
    );

    assign w_head_ctl = tag_ctl_t'(w_head_tag[TAG_W-1:PC_WIDTH]);
    assign w_head_pc  = w_head_tag[PC_WIDTH-1:0];

    assign issue_rdy = ~w_full;
    assign ALU_ack   = ALU_vld & ~w_empty & ~rst;

    // Reserved kind 3 falls through both decodes and behaves as DROP.
    assign w_is_wb  = (w_head_ctl.kind == KIND_WB_A);
    assign w_is_jmp = (w_head_ctl.kind == KIND_JMP);
    assign w_taken  = cond_taken(w_head_ctl.cond, eq, gt, ge, set);
    assign w_off    = w_taken ? w_head_ctl.jt : w_head_ctl.jf;
    assign w_target = w_head_pc + PC_WIDTH'(w_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            A_wr_en    <= 1'b0;
            A_wr_data  <= '0;
            pc_ld_en   <= 1'b0;
            pc_ld_val  <= '0;
            orphan_err <= 1'b0;
        end else begin
            A_wr_en  <= ALU_ack & w_is_wb;
            pc_ld_en <= ALU_ack & w_is_jmp;
            if (ALU_ack && w_is_wb)  A_wr_data <= ALU_out;
            if (ALU_ack && w_is_jmp) pc_ld_val <= w_target;
            if (ALU_vld && w_empty)  orphan_err <= 1'b1;
        end
    end

    assign idle = w_empty & ~A_wr_en & ~pc_ld_en;

endmodule

// File: tb/tb_alu_retire.sv
// Directed self-checking bench for alu_retire with hand-computed expectations.
module tb_alu_retire;

    logic        clk;
    logic        rst;
    logic        issue_vld;
    logic        issue_rdy;
    logic [1:0]  issue_kind;
    logic [1:0]  issue_cond;
    logic [7:0]  issue_jt;
    logic [7:0]  issue_jf;
    logic [9:0]  issue_pc;
    logic [31:0] ALU_out;
    logic        eq, gt, ge, set;
    logic        ALU_vld;
    logic        ALU_ack;
    logic        A_wr_en;
    logic [31:0] A_wr_data;
    logic        pc_ld_en;
    logic [9:0]  pc_ld_val;
    logic        idle;
    logic        orphan_err;

    int checks = 0;
    int errors = 0;

    alu_retire #(.PC_WIDTH(10), .TAG_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_vld  (issue_vld),
        .issue_rdy  (issue_rdy),
        .issue_kind (issue_kind),
        .issue_cond (issue_cond),
        .issue_jt   (issue_jt),
        .issue_jf   (issue_jf),
        .issue_pc   (issue_pc),
        .ALU_out    (ALU_out),
        .eq         (eq),
        .gt         (gt),
        .ge         (ge),
        .set        (set),
        .ALU_vld    (ALU_vld),
        .ALU_ack    (ALU_ack),
        .A_wr_en    (A_wr_en),
        .A_wr_data  (A_wr_data),
        .pc_ld_en   (pc_ld_en),
        .pc_ld_val  (pc_ld_val),
        .idle       (idle),
        .orphan_err (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] kind, input logic [1:0] cond,
                        input logic [7:0] jt, input logic [7:0] jf, input logic [9:0] pc);
        issue_vld  = 1'b1;
        issue_kind = kind;
        issue_cond = cond;
        issue_jt   = jt;
        issue_jf   = jf;
        issue_pc   = pc;
        tick();
        issue_vld  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", issue_rdy); end
        checks++; if (ALU_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ALU_ack); end
        checks++; if (A_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", A_wr_en); end
        checks++; if (A_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", A_wr_data); end
        checks++; if (pc_ld_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got %b exp 0", pc_ld_en); end
        checks++; if (pc_ld_val !== 10'd0) begin errors++; $display("FAIL reset_pc_val got %0d exp 0", pc_ld_val); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
        checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", orphan_err); end
    endtask

    task automatic test_wb();
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL wb_busy got %b exp 0", idle); end
        ALU_out = 32'h1234;
        ALU_vld = 1'b1;
        #1;
        checks++; if (ALU_ack !== 1'b1) begin errors++; $display("FAIL wb_ack got %b exp 1", ALU_ack); end
        tick();
        ALU_vld = 1'b0;
        checks++; if (A_wr_en !== 1'b1) begin errors++; $display("FAIL wb_en got %b exp 1", A_wr_en); end
        checks++; if (A_wr_data !== 32'h1234) begin errors++; $display("FAIL wb_data got %h exp 1234", A_wr_data); end
        checks++; if (pc_ld_en !== 1'b0) begin errors++; $display("FAIL wb_no_pc got %b exp 0", pc_ld_en); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL wb_idle_pulse got %b exp 0", idle); end
        tick();
        checks++; if (A_wr_en !== 1'b0) begin errors++; $display("FAIL wb_en_single got %b exp 0", A_wr_en); end
        checks++; if (A_wr_data !== 32'h1234) begin errors++; $display("FAIL wb_data_hold got %h exp 1234", A_wr_data); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL wb_idle got %b exp 1", idle); end
    endtask

    task automatic test_jmp(input logic gt_val, input logic [9:0] exp_val);
        push(2'd1, 2'd1, 8'd3, 8'd7, 10'd10);
        gt      = gt_val;
        eq      = ~gt_val;
        ALU_vld = 1'b1;
        tick();
        ALU_vld = 1'b0;
        checks++; if (pc_ld_en !== 1'b1) begin errors++; $display("FAIL jmp_en gt=%b got %b exp 1", gt_val, pc_ld_en); end
        checks++; if (pc_ld_val !== exp_val) begin errors++; $display("FAIL jmp_val gt=%b got %0d exp %0d", gt_val, pc_ld_val, exp_val); end
        checks++; if (A_wr_en !== 1'b0) begin errors++; $display("FAIL jmp_no_wb got %b exp 0", A_wr_en); end
        tick();
        gt = 1'b0; eq = 1'b0;
        checks++; if (pc_ld_en !== 1'b0) begin errors++; $display("FAIL jmp_en_single got %b exp 0", pc_ld_en); end
        checks++; if (pc_ld_val !== exp_val) begin errors++; $display("FAIL jmp_val_hold got %0d exp %0d", pc_ld_val, exp_val); end
    endtask

    task automatic test_wrap();
        push(2'd1, 2'd3, 8'd10, 8'd0, 10'd1020);
        set     = 1'b1;
        ALU_vld = 1'b1;
        tick();
        ALU_vld = 1'b0;
        set     = 1'b0;
        checks++; if (pc_ld_en !== 1'b1) begin errors++; $display("FAIL wrap_en got %b exp 1", pc_ld_en); end
        checks++; if (pc_ld_val !== 10'd6) begin errors++; $display("FAIL wrap_val got %0d exp 6", pc_ld_val); end
        tick();
    endtask

    task automatic test_back_to_back();
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        push(2'd1, 2'd0, 8'd1, 8'd2, 10'd4);
        ALU_out = 32'h0000_00AA;
        eq      = 1'b0;
        ALU_vld = 1'b1;
        #1;
        checks++; if (ALU_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", ALU_ack); end
        tick();
        eq = 1'b1;
        #1;
        checks++; if (ALU_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b exp 1", ALU_ack); end
        checks++; if (A_wr_en !== 1'b1) begin errors++; $display("FAIL b2b_wb_en got %b exp 1", A_wr_en); end
        checks++; if (A_wr_data !== 32'hAA) begin errors++; $display("FAIL b2b_wb_data got %h exp aa", A_wr_data); end
        tick();
        ALU_vld = 1'b0;
        eq      = 1'b0;
        checks++; if (A_wr_en !== 1'b0) begin errors++; $display("FAIL b2b_wb_off got %b exp 0", A_wr_en); end
        checks++; if (pc_ld_en !== 1'b1) begin errors++; $display("FAIL b2b_pc_en got %b exp 1", pc_ld_en); end
        checks++; if (pc_ld_val !== 10'd5) begin errors++; $display("FAIL b2b_pc_val got %0d exp 5", pc_ld_val); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", idle); end
    endtask

    task automatic test_push_pop();
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        // Push the jump in the same cycle the writeback retires.
        issue_vld  = 1'b1;
        issue_kind = 2'd1;
        issue_cond = 2'd2;
        issue_jt   = 8'd20;
        issue_jf   = 8'd30;
        issue_pc   = 10'd100;
        ALU_out    = 32'hDEAD_BEEF;
        ALU_vld    = 1'b1;
        ge         = 1'b0;
        #1;
        checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL pp_rdy got %b exp 1", issue_rdy); end
        checks++; if (ALU_ack !== 1'b1) begin errors++; $display("FAIL pp_ack1 got %b exp 1", ALU_ack); end
        tick();
        issue_vld = 1'b0;
        #1;
        checks++; if (ALU_ack !== 1'b1) begin errors++; $display("FAIL pp_ack2 got %b exp 1", ALU_ack); end
        checks++; if (A_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pp_wb_data got %h exp deadbeef", A_wr_data); end
        tick();
        ALU_vld = 1'b0;
        checks++; if (pc_ld_val !== 10'd130) begin errors++; $display("FAIL pp_pc_val got %0d exp 130", pc_ld_val); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL pp_idle got %b exp 1", idle); end
    endtask

    task automatic test_drop();
        push(2'd2, 2'd0, 8'd0, 8'd0, 10'd0);
        push(2'd3, 2'd0, 8'd0, 8'd0, 10'd0);
        ALU_vld = 1'b1;
        tick();
        checks++; if (A_wr_en !== 1'b0 || pc_ld_en !== 1'b0) begin errors++; $display("FAIL drop_pulse got wb=%b pc=%b exp 0 0", A_wr_en, pc_ld_en); end
        tick();
        ALU_vld = 1'b0;
        checks++; if (A_wr_en !== 1'b0 || pc_ld_en !== 1'b0) begin errors++; $display("FAIL rsvd_pulse got wb=%b pc=%b exp 0 0", A_wr_en, pc_ld_en); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drop_idle got %b exp 1", idle); end
        checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL drop_orphan got %b exp 0", orphan_err); end
    endtask

    task automatic test_full();
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        checks++; if (issue_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", issue_rdy); end
        push(2'd1, 2'd3, 8'd1, 8'd1, 10'd0);
        checks++; if (issue_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy2 got %b exp 0", issue_rdy); end
        ALU_out = 32'h55;
        set     = 1'b1;
        ALU_vld = 1'b1;
        tick();
        tick();
        ALU_vld = 1'b0;
        set     = 1'b0;
        checks++; if (A_wr_en !== 1'b1) begin errors++; $display("FAIL full_wb2 got %b exp 1", A_wr_en); end
        tick();
        checks++; if (pc_ld_en !== 1'b0) begin errors++; $display("FAIL full_dropped_push got %b exp 0", pc_ld_en); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_idle got %b exp 1", idle); end
    endtask

    task automatic test_orphan();
        do_reset();
        ALU_vld = 1'b1;
        #1;
        checks++; if (ALU_ack !== 1'b0) begin errors++; $display("FAIL orphan_ack got %b exp 0", ALU_ack); end
        tick();
        ALU_vld = 1'b0;
        checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", orphan_err); end
        tick();
        tick();
        checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", orphan_err); end
        do_reset();
        checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b exp 0", orphan_err); end
    endtask

    task automatic test_reset_mid_op();
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        push(2'd0, 2'd0, 8'd0, 8'd0, 10'd0);
        ALU_out = 32'h9999;
        ALU_vld = 1'b1;
        rst     = 1'b1;
        #1;
        checks++; if (ALU_ack !== 1'b0) begin errors++; $display("FAIL mid_ack got %b exp 0", ALU_ack); end
        tick();
        rst     = 1'b0;
        ALU_vld = 1'b0;
        checks++; if (A_wr_en !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got %b exp 0", A_wr_en); end
        checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b exp 1", issue_rdy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", idle); end
        checks++; if (A_wr_data !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", A_wr_data); end
    endtask

    initial begin
        rst = 1'b1; issue_vld = 1'b0; issue_kind = '0; issue_cond = '0;
        issue_jt = '0; issue_jf = '0; issue_pc = '0; ALU_out = '0;
        eq = 1'b0; gt = 1'b0; ge = 1'b0; set = 1'b0; ALU_vld = 1'b0;
        test_reset();
        test_wb();
        test_jmp(1'b1, 10'd13);
        test_jmp(1'b0, 10'd17);
        test_wrap();
        test_back_to_back();
        test_push_pop();
        test_drop();
        test_full();
        test_orphan();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
